mem_bus_responder: RTL and testbench

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

---
 rtl/mem_bus_responder.sv | 121 ++++++++++++
 tb/tb_mem_bus_responder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: single-port 32-bit RAM behind a tagged request/acknowledge
// bus. Requests are acknowledged combinationally by echoing their tag. Reads
// return through a fixed-latency pipeline. An optional periodic refusal cycle
// emulates DRAM refresh.
//
// Handshake: an initiator raises mem_req_request with a non-zero tag and holds
// every request field stable until mem_resp_rack_tag equals that tag in the same
// cycle. The transfer happens at the rising edge that closes that cycle. Read
// data comes back exactly READ_LATENCY cycles after the accept cycle, flagged
// by mem_resp_dack_tag. There is no backpressure on the response side.
`timescale 1ns/1ps

module mem_bus_responder #(
  parameter int ADDR_BITS    = 10,
  parameter int READ_LATENCY = 2,
  parameter int STALL_PERIOD = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [25:0] mem_req_address,
  input  logic [3:0]  mem_req_byte_en,
  input  logic        mem_req_read_writen,
  input  logic        mem_req_request,
  input  logic [7:0]  mem_req_tag,
  input  logic [31:0] mem_req_wdata,
  output logic [7:0]  mem_resp_rack_tag,
  output logic [7:0]  mem_resp_dack_tag,
  output logic [31:0] mem_resp_data
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CNT_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam bit STALL_EN = (STALL_PERIOD != 0);
  localparam logic [CNT_W-1:0] STALL_LAST =
    (STALL_PERIOD > 0) ? CNT_W'(STALL_PERIOD - 1) : '0;

  // Refresh emulation state.
  logic [CNT_W-1:0] stall_count;
  logic             stall_cycle;

  // Accept decode.
  logic                 accept;
  logic                 rd_accept;
  logic                 wr_accept;
  logic [ADDR_BITS-1:0] word_index;

  // Byte-address bits that do not select a word. They alias by design.
  logic unused_addr_bits;

  // Storage and read pipeline. Stage 0 is loaded at the accept edge.
  // Stage READ_LATENCY-1 drives the response outputs.
  logic [31:0] ram        [DEPTH];
  logic        pipe_valid [READ_LATENCY];
  logic [7:0]  pipe_tag   [READ_LATENCY];
  logic [31:0] pipe_data  [READ_LATENCY];

  assign stall_cycle = STALL_EN && (stall_count == STALL_LAST);
  assign accept      = mem_req_request && !stall_cycle && !reset;
  assign rd_accept   = accept && mem_req_read_writen;
  assign wr_accept   = accept && !mem_req_read_writen;
  assign word_index  = mem_req_address[ADDR_BITS+1:2];

  assign unused_addr_bits = ^{mem_req_address[25:ADDR_BITS+2], mem_req_address[1:0]};

  // The request acknowledge is combinational. It never shows a tag unless a
  // request is actually being taken this cycle.
  assign mem_resp_rack_tag = accept ? mem_req_tag : 8'h00;

  // Response outputs read as zero unless the last pipeline stage holds a read.
  assign mem_resp_dack_tag = (pipe_valid[READ_LATENCY-1] && !reset)
                             ? pipe_tag[READ_LATENCY-1] : 8'h00;
  assign mem_resp_data     = (pipe_valid[READ_LATENCY-1] && !reset)
                             ? pipe_data[READ_LATENCY-1] : 32'h0000_0000;

  // Free-running refusal counter. The cycle with count STALL_PERIOD-1 refuses.
  always_ff @(posedge clock) begin
    if (reset || !STALL_EN) begin
      stall_count <= '0;
    end else if (stall_count == STALL_LAST) begin
      stall_count <= '0;
    end else begin
      stall_count <= stall_count + 1'b1;
    end
  end

  // Pipeline valid bits are the only response state that must clear on reset.
  // This drops in-flight reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_valid[k] <= 1'b0;
      end
    end else begin
      pipe_valid[0] <= rd_accept;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
      end
    end
  end

  // Tag and data ride alongside the valid bits. They need no reset because the
  // valid bits gate them. RAM contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_req_byte_en[b]) begin
          ram[word_index][8*b +: 8] <= mem_req_wdata[8*b +: 8];
        end
      end
    end
    if (rd_accept) begin
      pipe_tag[0]  <= mem_req_tag;
      pipe_data[0] <= ram[word_index];
    end
    for (int k = 1; k < READ_LATENCY; k++) begin
      pipe_tag[k]  <= pipe_tag[k-1];
      pipe_data[k] <= pipe_data[k-1];
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder. The main instance uses the default
// parameters. A second instance with STALL_PERIOD=4 covers refresh refusals.
// Inputs change 1ns after a rising edge. Outputs are sampled on the falling
// edge of the same cycle.
`timescale 1ns/1ps

module tb_mem_bus_responder;

  // Clock and reset.
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Main instance signals.
  logic [25:0] address;
  logic [3:0]  byte_en;
  logic        read_writen;
  logic        request;
  logic [7:0]  tag;
  logic [31:0] wdata;
  logic [7:0]  rack;
  logic [7:0]  dack;
  logic [31:0] rdata;

  // Stall instance signals.
  logic [25:0] s_address;
  logic [3:0]  s_byte_en;
  logic        s_read_writen;
  logic        s_request;
  logic [7:0]  s_tag;
  logic [31:0] s_wdata;
  logic [7:0]  s_rack;
  logic [7:0]  s_dack;
  logic [31:0] s_rdata;

  int n_vec = 0;
  int n_err = 0;

  mem_bus_responder dut (
    .clock               (clock),
    .reset               (reset),
    .mem_req_address     (address),
    .mem_req_byte_en     (byte_en),
    .mem_req_read_writen (read_writen),
    .mem_req_request     (request),
    .mem_req_tag         (tag),
    .mem_req_wdata       (wdata),
    .mem_resp_rack_tag   (rack),
    .mem_resp_dack_tag   (dack),
    .mem_resp_data       (rdata)
  );

  mem_bus_responder #(.STALL_PERIOD(4)) dut_stall (
    .clock               (clock),
    .reset               (reset),
    .mem_req_address     (s_address),
    .mem_req_byte_en     (s_byte_en),
    .mem_req_read_writen (s_read_writen),
    .mem_req_request     (s_request),
    .mem_req_tag         (s_tag),
    .mem_req_wdata       (s_wdata),
    .mem_resp_rack_tag   (s_rack),
    .mem_resp_dack_tag   (s_dack),
    .mem_resp_data       (s_rdata)
  );

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic drive_write(input logic [25:0] a, input logic [3:0] be,
                             input logic [31:0] d, input logic [7:0] t);
    address = a; byte_en = be; wdata = d; tag = t;
    read_writen = 1'b0; request = 1'b1;
  endtask

  task automatic drive_read(input logic [25:0] a, input logic [7:0] t);
    address = a; byte_en = 4'h0; wdata = 32'h0; tag = t;
    read_writen = 1'b1; request = 1'b1;
  endtask

  task automatic drive_idle();
    request = 1'b0; tag = 8'h00; read_writen = 1'b1; byte_en = 4'h0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // A write is pending throughout reset. It must be taken on the first free cycle.
    reset = 1'b1;
    drive_write(26'h080, 4'hF, 32'hCAFE_F00D, 8'h55);
    next_cycle();
    sample();
    n_vec++; if (rack !== 8'h00) begin n_err++; $display("FAIL reset_rack: got %h want %h", rack, 8'h00); end
    n_vec++; if (dack !== 8'h00) begin n_err++; $display("FAIL reset_dack: got %h want %h", dack, 8'h00); end
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want %h", rdata, 32'h0); end
    next_cycle();
    reset = 1'b0;
    sample();
    n_vec++; if (rack !== 8'h55) begin n_err++; $display("FAIL release_accept: got %h want %h", rack, 8'h55); end
  endtask

  task automatic test_write_read();
    next_cycle();
    drive_write(26'h040, 4'hF, 32'h1234_5678, 8'h11);
    sample();
    n_vec++; if (rack !== 8'h11) begin n_err++; $display("FAIL wr_rack: got %h want %h", rack, 8'h11); end
    next_cycle();
    drive_read(26'h040, 8'h22);
    sample();
    n_vec++; if (rack !== 8'h22) begin n_err++; $display("FAIL rd_rack: got %h want %h", rack, 8'h22); end
    n_vec++; if (dack !== 8'h00) begin n_err++; $display("FAIL wr_no_dack: got %h want %h", dack, 8'h00); end
    next_cycle();
    drive_idle();
    sample();
    n_vec++; if (rack !== 8'h00) begin n_err++; $display("FAIL idle_rack: got %h want %h", rack, 8'h00); end
    n_vec++; if (dack !== 8'h00) begin n_err++; $display("FAIL early_dack: got %h want %h", dack, 8'h00); end
    next_cycle();
    sample();
    n_vec++; if (dack !== 8'h22) begin n_err++; $display("FAIL raw_dack: got %h want %h", dack, 8'h22); end
    n_vec++; if (rdata !== 32'h1234_5678) begin n_err++; $display("FAIL raw_data: got %h want %h", rdata, 32'h1234_5678); end
    next_cycle();
    sample();
    n_vec++; if (dack !== 8'h00) begin n_err++; $display("FAIL dack_one_cycle: got %h want %h", dack, 8'h00); end
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL data_zero: got %h want %h", rdata, 32'h0); end
  endtask

  task automatic test_partial_write();
    next_cycle();
    drive_write(26'h040, 4'b0101, 32'hAABB_CCDD, 8'h33);
    sample();
    n_vec++; if (rack !== 8'h33) begin n_err++; $display("FAIL pw_rack: got %h want %h", rack, 8'h33); end
    next_cycle();
    drive_write(26'h040, 4'b0000, 32'hFFFF_FFFF, 8'h35);
    sample();
    n_vec++; if (rack !== 8'h35) begin n_err++; $display("FAIL be0_rack: got %h want %h", rack, 8'h35); end
    next_cycle();
    drive_read(26'h040, 8'h34);
    next_cycle();
    drive_idle();
    next_cycle();
    sample();
    n_vec++; if (dack !== 8'h34) begin n_err++; $display("FAIL pw_dack: got %h want %h", dack, 8'h34); end
    n_vec++; if (rdata !== 32'h12BB_56DD) begin n_err++; $display("FAIL pw_data: got %h want %h", rdata, 32'h12BB_56DD); end
  endtask

  task automatic test_back_to_back();
    logic [39:0] exp_q[$];
    logic [39:0] exp;
    logic [31:0] vals [4] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drive_write(26'h100 + 26'(4 * i), 4'hF, vals[i], 8'h41 + 8'(i));
      sample();
      n_vec++; if (rack !== 8'h41 + 8'(i)) begin n_err++; $display("FAIL b2b_wr_rack%0d: got %h want %h", i, rack, 8'h41 + 8'(i)); end
    end
    // Four reads back to back. A write is accepted while the third read returns.
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      if (c < 4) begin
        drive_read(26'h100 + 26'(4 * c), 8'(c + 1));
        exp_q.push_back({8'(c + 1), vals[c]});
      end else if (c == 4) begin
        drive_write(26'h200, 4'hF, 32'h5555_AAAA, 8'h50);
      end else begin
        drive_idle();
      end
      sample();
      if (c < 4) begin
        n_vec++; if (rack !== 8'(c + 1)) begin n_err++; $display("FAIL b2b_rd_rack%0d: got %h want %h", c, rack, 8'(c + 1)); end
      end else if (c == 4) begin
        n_vec++; if (rack !== 8'h50) begin n_err++; $display("FAIL b2b_wr_during_dack: got %h want %h", rack, 8'h50); end
      end
      if (c >= 2) begin
        exp = exp_q.pop_front();
        n_vec++; if (dack !== exp[39:32]) begin n_err++; $display("FAIL b2b_dack%0d: got %h want %h", c, dack, exp[39:32]); end
        n_vec++; if (rdata !== exp[31:0]) begin n_err++; $display("FAIL b2b_data%0d: got %h want %h", c, rdata, exp[31:0]); end
      end else begin
        n_vec++; if (dack !== 8'h00) begin n_err++; $display("FAIL b2b_nodack%0d: got %h want %h", c, dack, 8'h00); end
      end
    end
    next_cycle();
    drive_read(26'h200, 8'h51);
    next_cycle();
    drive_idle();
    sample();
    n_vec++; if (dack !== 8'h00) begin n_err++; $display("FAIL b2b_drained: got %h want %h", dack, 8'h00); end
    next_cycle();
    sample();
    n_vec++; if (dack !== 8'h51) begin n_err++; $display("FAIL wr_during_dack_tag: got %h want %h", dack, 8'h51); end
    n_vec++; if (rdata !== 32'h5555_AAAA) begin n_err++; $display("FAIL wr_during_dack_data: got %h want %h", rdata, 32'h5555_AAAA); end
  endtask

  task automatic test_alias();
    logic [25:0] addrs [4] = '{26'h000_0040, 26'h000_0041, 26'h3FF_F040, 26'h000_0080};
    logic [31:0] exps  [4] = '{32'h0BAD_CAFE, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 32'hCAFE_F00D};
    next_cycle();
    drive_write(26'h000_1040, 4'hF, 32'h0BAD_CAFE, 8'h60);
    sample();
    n_vec++; if (rack !== 8'h60) begin n_err++; $display("FAIL alias_wr_rack: got %h want %h", rack, 8'h60); end
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      if (c < 4) drive_read(addrs[c], 8'h61 + 8'(c));
      else drive_idle();
      sample();
      if (c >= 2) begin
        n_vec++; if (dack !== 8'h61 + 8'(c - 2)) begin n_err++; $display("FAIL alias_dack%0d: got %h want %h", c - 2, dack, 8'h61 + 8'(c - 2)); end
        n_vec++; if (rdata !== exps[c - 2]) begin n_err++; $display("FAIL alias_data%0d: got %h want %h", c - 2, rdata, exps[c - 2]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    drive_read(26'h040, 8'h70);
    sample();
    n_vec++; if (rack !== 8'h70) begin n_err++; $display("FAIL mid_rack: got %h want %h", rack, 8'h70); end
    next_cycle();
    drive_idle();
    reset = 1'b1;
    next_cycle();
    sample();
    n_vec++; if (dack !== 8'h00) begin n_err++; $display("FAIL mid_in_reset: got %h want %h", dack, 8'h00); end
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      sample();
      n_vec++; if (dack !== 8'h00) begin n_err++; $display("FAIL mid_discard%0d: got %h want %h", c, dack, 8'h00); end
      next_cycle();
    end
    drive_read(26'h040, 8'h71);
    next_cycle();
    drive_idle();
    next_cycle();
    sample();
    n_vec++; if (dack !== 8'h71) begin n_err++; $display("FAIL mid_reread_tag: got %h want %h", dack, 8'h71); end
    n_vec++; if (rdata !== 32'h0BAD_CAFE) begin n_err++; $display("FAIL mid_reread_data: got %h want %h", rdata, 32'h0BAD_CAFE); end
  endtask

  task automatic test_stall();
    // Expected acknowledge per cycle after release. Every fourth cycle refuses.
    logic [7:0] exp_rack [10] = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h04,
                                  8'h05, 8'h06, 8'h00, 8'h07, 8'h08};
    logic [7:0] cur;
    next_cycle();
    reset = 1'b1;
    cur = 8'h01;
    s_address = 26'h040; s_byte_en = 4'hF; s_wdata = 32'h0000_0001;
    s_read_writen = 1'b0; s_tag = cur; s_request = 1'b1;
    sample();
    n_vec++; if (s_rack !== 8'h00) begin n_err++; $display("FAIL stall_reset_rack: got %h want %h", s_rack, 8'h00); end
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sample();
      n_vec++; if (s_rack !== exp_rack[k]) begin n_err++; $display("FAIL stall_rack%0d: got %h want %h", k, s_rack, exp_rack[k]); end
      next_cycle();
      if (exp_rack[k] != 8'h00) begin
        cur = cur + 8'h01;
        s_tag = cur;
        s_address = 26'h040 + 26'(4 * cur);
        s_wdata = 32'(cur);
      end
    end
    s_request = 1'b0;
    s_tag = 8'h00;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    drive_idle();
    address = '0; wdata = '0;
    s_address = '0; s_byte_en = '0; s_read_writen = 1'b1;
    s_request = 1'b0; s_tag = '0; s_wdata = '0;
    test_reset();
    test_write_read();
    test_partial_write();
    test_back_to_back();
    test_alias();
    test_reset_mid();
    test_stall();
    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
